multi_timer: RTL and testbench

Parametrised C-channel, N-bit up-counting timer bank, the successor of the single fixed-terminal timer. Each channel has a programmable step and terminal value captured at start, a one-shot or periodic mode, stop/retrigger control, and optional chaining so one channel's terminal event starts the next. It sits beside the game/display control logic as the shared source of frame, animation and delay timing.

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_channel.sv | 76 +++++++
 rtl/multi_timer.sv | 48 ++++
 tb/tb_multi_timer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and default sizing for the multi-channel timer bank.
package timer_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_C = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: operands captured at go, saturating up-count,
// one-cycle end pulse, then periodic reload or one-shot hold.
module timer_channel
  import timer_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         go,
  input  logic         stop,
  input  logic         periodic,
  input  logic [N-1:0] step,
  input  logic [N-1:0] term,
  output logic         active,
  output logic         end_pulse,
  output logic [N-1:0] count
);

  state_t       state;
  logic [N-1:0] step_cap;
  logic [N-1:0] term_cap;
  logic         periodic_cap;
  logic [N:0]   sum;

  // One extra bit so a large step saturates at term instead of wrapping.
  assign sum = {1'b0, count} + {1'b0, step_cap};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= IDLE;
      count        <= '0;
      active       <= 1'b0;
      end_pulse    <= 1'b0;
      step_cap     <= '0;
      term_cap     <= '0;
      periodic_cap <= 1'b0;
    end else if (stop) begin
      state     <= IDLE;
      active    <= 1'b0;
      end_pulse <= 1'b0;
    end else if (go) begin
      state        <= RUN;
      count        <= '0;
      active       <= 1'b1;
      end_pulse    <= 1'b0;
      step_cap     <= step;
      term_cap     <= term;
      periodic_cap <= periodic;
    end else begin
      end_pulse <= 1'b0;
      unique case (state)
        RUN: begin
          // The cycle showing term is followed by either reload or hold.
          if (end_pulse) begin
            if (periodic_cap) begin
              count <= '0;
            end else begin
              state  <= HOLD;
              active <= 1'b0;
            end
          end else if (sum >= {1'b0, term_cap}) begin
            count     <= term_cap;
            end_pulse <= 1'b1;
          end else begin
            count <= sum[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_timer.sv
// C-channel timer bank: builds the per-channel start (with optional chaining
// from the previous channel's end pulse) and slices the packed operand buses.
module multi_timer
  import timer_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int C = DEF_C
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic [C-1:0]   start,
  input  logic [C-1:0]   stop,
  input  logic [C-1:0]   periodic,
  input  logic           chain_en,
  input  logic [C*N-1:0] step,
  input  logic [C*N-1:0] term,
  output logic [C-1:0]   countActive,
  output logic [C-1:0]   countEnd,
  output logic [C*N-1:0] countT
);

  logic [C-1:0] go;

  // NOTE: go gets a full default before the loop, so no bit can hold its
  // old value and no latch is inferred.
  always_comb begin
    go = start;
    for (int i = 1; i < C; i++) begin
      go[i] = start[i] | (chain_en & countEnd[i-1]);
    end
  end

  for (genvar i = 0; i < C; i++) begin : g_ch
    timer_channel #(.N(N)) u_ch (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .go        (go[i]),
      .stop      (stop[i]),
      .periodic  (periodic[i]),
      .step      (step[i*N +: N]),
      .term      (term[i*N +: N]),
      .active    (countActive[i]),
      .end_pulse (countEnd[i]),
      .count     (countT[i*N +: N])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (N = 8, C = 4).
module tb_multi_timer;

  localparam int N = 8;
  localparam int C = 4;

  logic           Clk;
  logic           Reset_n;
  logic [C-1:0]   start;
  logic [C-1:0]   stop;
  logic [C-1:0]   periodic;
  logic           chain_en;
  logic [C*N-1:0] step;
  logic [C*N-1:0] term;
  logic [C-1:0]   countActive;
  logic [C-1:0]   countEnd;
  logic [C*N-1:0] countT;

  int tests = 0;
  int fails = 0;

  multi_timer #(.N(N), .C(C)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .start       (start),
    .stop        (stop),
    .periodic    (periodic),
    .chain_en    (chain_en),
    .step        (step),
    .term        (term),
    .countActive (countActive),
    .countEnd    (countEnd),
    .countT      (countT)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [N-1:0] s, input logic [N-1:0] t,
                        input logic p);
    step[ch*N +: N] = s;
    term[ch*N +: N] = t;
    periodic[ch]    = p;
  endtask

  // {active, end, count} of one channel
  function automatic logic [N+1:0] st(input int ch);
    return {countActive[ch], countEnd[ch], countT[ch*N +: N]};
  endfunction

  task automatic stop_all();
    stop = '1;
    tick();
    stop = '0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    tests++;
    if ({countActive, countEnd, countT} !== '0) begin
      fails++;
      $display("FAIL reset_initial got a=%b e=%b t=%h exp all zero", countActive, countEnd, countT);
    end
    Reset_n = 1'b1;
    for (int i = 0; i < C; i++) set_ch(i, 8'd1, 8'd100, 1'b0);
    start = '1;
    tick();
    start = '0;
    tick(); tick(); tick();
    tests++;
    if (countT !== {4{8'd3}} || countActive !== 4'hF) begin
      fails++;
      $display("FAIL reset_precount got a=%b t=%h exp a=1111 t=03030303", countActive, countT);
    end
    Reset_n = 1'b0;
    tick();
    tests++;
    if ({countActive, countEnd, countT} !== '0) begin
      fails++;
      $display("FAIL reset_midcount got a=%b e=%b t=%h exp all zero", countActive, countEnd, countT);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_one_shot();
    set_ch(0, 8'd1, 8'd5, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tests++;
    if (st(0) !== {1'b1, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL oneshot_go got %b exp %b", st(0), {1'b1, 1'b0, 8'd0});
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      tests++;
      if (st(0) !== {1'b1, (i == 5), 8'(i)}) begin
        fails++;
        $display("FAIL oneshot_count edge %0d got %b exp %b", i, st(0), {1'b1, (i == 5), 8'(i)});
      end
    end
    for (int i = 6; i <= 7; i++) begin
      tick();
      tests++;
      if (st(0) !== {1'b0, 1'b0, 8'd5}) begin
        fails++;
        $display("FAIL oneshot_hold edge %0d got %b exp %b", i, st(0), {1'b0, 1'b0, 8'd5});
      end
    end
  endtask

  task automatic test_periodic();
    int seq[12] = '{0, 3, 6, 9, 10, 0, 3, 6, 9, 10, 0, 3};
    set_ch(1, 8'd3, 8'd10, 1'b1);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      tests++;
      if (st(1) !== {1'b1, (seq[i] == 10), 8'(seq[i])}) begin
        fails++;
        $display("FAIL periodic cycle %0d got %b exp %b", i, st(1),
                 {1'b1, (seq[i] == 10), 8'(seq[i])});
      end
    end
    stop_all();
  endtask

  task automatic test_saturation();
    int seq[3] = '{0, 200, 250};
    set_ch(2, 8'd200, 8'd250, 1'b0);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      tests++;
      if (st(2) !== {1'b1, (i == 2), 8'(seq[i])}) begin
        fails++;
        $display("FAIL saturate cycle %0d got %b exp %b", i, st(2), {1'b1, (i == 2), 8'(seq[i])});
      end
    end
    tick();
    tests++;
    if (st(2) !== {1'b0, 1'b0, 8'd250}) begin
      fails++;
      $display("FAIL saturate_hold got %b exp %b", st(2), {1'b0, 1'b0, 8'd250});
    end
  endtask

  task automatic test_chain();
    stop_all();
    chain_en = 1'b1;
    set_ch(0, 8'd1, 8'd3, 1'b0);
    set_ch(1, 8'd1, 8'd2, 1'b0);
    set_ch(2, 8'd1, 8'd1, 1'b0);
    set_ch(3, 8'd1, 8'd1, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      case (c)
        3: begin
          tests++;
          if (st(0) !== {1'b1, 1'b1, 8'd3} || countActive[1] !== 1'b0) begin
            fails++;
            $display("FAIL chain_ch0_end got %b a1=%b exp %b a1=0", st(0), countActive[1],
                     {1'b1, 1'b1, 8'd3});
          end
        end
        4, 5, 6: begin
          tests++;
          if (st(1) !== {1'b1, (c == 6), 8'(c - 4)}) begin
            fails++;
            $display("FAIL chain_ch1 cycle %0d got %b exp %b", c, st(1), {1'b1, (c == 6), 8'(c - 4)});
          end
        end
        7: begin
          tests++;
          if (st(2) !== {1'b1, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL chain_ch2_go got %b exp %b", st(2), {1'b1, 1'b0, 8'd0});
          end
        end
        10: begin
          tests++;
          if (st(3) !== {1'b1, 1'b1, 8'd1}) begin
            fails++;
            $display("FAIL chain_ch3_end got %b exp %b", st(3), {1'b1, 1'b1, 8'd1});
          end
        end
        11, 12: begin
          tests++;
          if (st(0) !== {1'b0, 1'b0, 8'd3}) begin
            fails++;
            $display("FAIL chain_no_wrap cycle %0d got %b exp %b", c, st(0), {1'b0, 1'b0, 8'd3});
          end
        end
        default: ;
      endcase
    end
    chain_en = 1'b0;
  endtask

  task automatic test_stop_retrigger();
    stop_all();
    set_ch(0, 8'd2, 8'd100, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    tick();
    start[0] = 1'b0;
    stop[0]  = 1'b0;
    tests++;
    if (st(0) !== {1'b0, 1'b0, 8'd4}) begin
      fails++;
      $display("FAIL stop_wins got %b exp %b", st(0), {1'b0, 1'b0, 8'd4});
    end
    tick();
    tests++;
    if (st(0) !== {1'b0, 1'b0, 8'd4}) begin
      fails++;
      $display("FAIL stop_idle_hold got %b exp %b", st(0), {1'b0, 1'b0, 8'd4});
    end
    set_ch(0, 8'd1, 8'd50, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick(); tick(); tick(); tick();
    tests++;
    if (st(0) !== {1'b1, 1'b0, 8'd4}) begin
      fails++;
      $display("FAIL retrig_pre got %b exp %b", st(0), {1'b1, 1'b0, 8'd4});
    end
    set_ch(0, 8'd5, 8'd20, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    set_ch(0, 8'd9, 8'd7, 1'b1);
    tests++;
    if (st(0) !== {1'b1, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL retrig_zero got %b exp %b", st(0), {1'b1, 1'b0, 8'd0});
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++;
      if (st(0) !== {1'b1, (i == 4), 8'(5 * i)}) begin
        fails++;
        $display("FAIL retrig_count %0d got %b exp %b", i, st(0), {1'b1, (i == 4), 8'(5 * i)});
      end
    end
    tick();
    tests++;
    if (st(0) !== {1'b0, 1'b0, 8'd20}) begin
      fails++;
      $display("FAIL retrig_oneshot_kept got %b exp %b", st(0), {1'b0, 1'b0, 8'd20});
    end
  endtask

  task automatic test_boundaries();
    stop_all();
    // go on the terminal edge restarts instead of holding
    set_ch(0, 8'd1, 8'd2, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tests++;
    if (st(0) !== {1'b1, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL go_on_term got %b exp %b", st(0), {1'b1, 1'b0, 8'd0});
    end
    tick();
    tests++;
    if (st(0) !== {1'b1, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL go_on_term_next got %b exp %b", st(0), {1'b1, 1'b0, 8'd1});
    end
    // step 0: stuck at 0 while running; term 0: terminal on first edge
    set_ch(1, 8'd0, 8'd5, 1'b0);
    set_ch(2, 8'd4, 8'd0, 1'b0);
    start[2:1] = 2'b11;
    tick();
    start[2:1] = 2'b00;
    tick();
    tests++;
    if (st(1) !== {1'b1, 1'b0, 8'd0} || st(2) !== {1'b1, 1'b1, 8'd0}) begin
      fails++;
      $display("FAIL zero_ops got ch1=%b ch2=%b exp ch1=%b ch2=%b", st(1), st(2),
               {1'b1, 1'b0, 8'd0}, {1'b1, 1'b1, 8'd0});
    end
    tick();
    tick();
    tests++;
    if (st(1) !== {1'b1, 1'b0, 8'd0} || st(2) !== {1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL zero_ops_later got ch1=%b ch2=%b exp ch1=%b ch2=%b", st(1), st(2),
               {1'b1, 1'b0, 8'd0}, {1'b0, 1'b0, 8'd0});
    end
  endtask

  initial begin
    Reset_n  = 1'b0;
    start    = '0;
    stop     = '0;
    periodic = '0;
    chain_en = 1'b0;
    step     = '0;
    term     = '0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_saturation();
    test_chain();
    test_stop_retrigger();
    test_boundaries();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
